// File: rtl/data_wbuf.sv
// data_wbuf: store buffer between the core data port and the memory bridge.
// Stores are acknowledged one cycle after acceptance and drained in order.
// A load is issued only once the buffer is empty and no store ack is pending.
module data_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, ST_REQ, ST_WAIT, LD_REQ, LD_WAIT} state_t;

  state_t        state;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          ack_p1;

  logic [31:0]   q_addr  [DEPTH];
  logic [1:0]    q_size  [DEPTH];
  logic [3:0]    q_wstrb [DEPTH];
  logic [31:0]   q_wdata [DEPTH];
  logic [31:0]   ld_addr;
  logic [1:0]    ld_size;

  logic          push;
  logic          pop;
  logic          ld_acc;
  logic          ld_done;

  // Acceptance and pop decisions; gated by reset so outputs are quiet while held.
  always_comb begin
    push      = aresetn && cpu_req && cpu_wr && (count < CW'(DEPTH)) &&
                (state != LD_REQ) && (state != LD_WAIT);
    ld_acc    = aresetn && cpu_req && !cpu_wr && (state == IDLE) &&
                (count == '0) && !ack_p1;
    pop       = (state == ST_WAIT) && mem_data_ok;
    ld_done   = (state == LD_WAIT) && mem_data_ok;
    count_nxt = count + CW'(push) - CW'(pop);
  end

  // Core-side responses: store ack is the registered pulse, load data is passed through.
  always_comb begin
    cpu_addr_ok = push | ld_acc;
    cpu_data_ok = ack_p1 | ld_done;
    cpu_rdata   = ld_done ? mem_rdata : '0;
  end

  // Bridge-side request, driven from the head entry or the load register.
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_REQ: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_size  = q_size[head];
        mem_wstrb = q_wstrb[head];
        mem_addr  = q_addr[head];
        mem_wdata = q_wdata[head];
      end
      LD_REQ: begin
        mem_req   = 1'b1;
        mem_size  = ld_size;
        mem_addr  = ld_addr;
      end
      default: ;
    endcase
  end

  // Payload storage: queue entries and the load address, no reset needed.
  always_ff @(posedge aclk) begin
    if (push) begin
      q_addr[tail]  <= cpu_addr;
      q_size[tail]  <= cpu_size;
      q_wstrb[tail] <= cpu_wstrb;
      q_wdata[tail] <= cpu_wdata;
    end
    if (ld_acc) begin
      ld_addr <= cpu_addr;
      ld_size <= cpu_size;
    end
  end

  // Control: pointers, occupancy, store-ack pulse and the bridge FSM.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      ack_p1 <= 1'b0;
    end else begin
      ack_p1 <= push;
      count  <= count_nxt;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case (state)
        IDLE: begin
          if (count != '0) state <= ST_REQ;
          else if (ld_acc) state <= LD_REQ;
        end
        ST_REQ:  if (mem_addr_ok) state <= ST_WAIT;
        ST_WAIT: if (pop) state <= (count_nxt != '0) ? ST_REQ : IDLE;
        LD_REQ:  if (mem_addr_ok) state <= LD_WAIT;
        LD_WAIT: if (mem_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_wbuf.md
DATA_WBUF -- requirements
Module: data_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, store-queue entries (power of two, >=2).
REQ-002 SHALL have port aclk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_req  in  1  core data request.
REQ-005 SHALL have port cpu_wr  in  1  1=store, 0=load.
REQ-006 SHALL have port cpu_size  in  2  0=byte, 1=half, 2=word.
REQ-007 SHALL have port cpu_wstrb  in  4  store byte enables.
REQ-008 SHALL have port cpu_addr  in  32  request address.
REQ-009 SHALL have port cpu_wdata  in  32  store data.
REQ-010 SHALL have port cpu_addr_ok  out  1  request accepted this cycle.
REQ-011 SHALL have port cpu_data_ok  out  1  one response completes this cycle.
REQ-012 SHALL have port cpu_rdata  out  32  load data, valid with load cpu_data_ok.
REQ-013 SHALL have ports mem_req/mem_wr/mem_size/mem_wstrb/mem_addr/mem_wdata  out  1/1/2/4/32/32  bridge-side request, same meaning as cpu_* counterparts.
REQ-014 SHALL have ports mem_addr_ok/mem_data_ok  in  1/1, and mem_rdata  in  32, bridge-side handshake and load data.

Function
REQ-015 SHALL queue stores FIFO: entry = {addr, size, wstrb, wdata}; count 0..DEPTH; head/tail pointers wrap modulo DEPTH.
REQ-016 SHALL accept a store (cpu_addr_ok=1, combinational) when cpu_req&cpu_wr & count<DEPTH & state not LD_REQ/LD_WAIT; entry written at that edge.
REQ-017 SHALL deassert cpu_addr_ok for stores when count==DEPTH (full); request held by core, no entry lost.
REQ-018 SHALL pulse cpu_data_ok exactly one cycle after each accepted store (registered), independent of drain progress.
REQ-019 SHALL accept a load only when state==IDLE, count==0, no store-ack pulse pending; captures addr/size into a load register and moves to LD_REQ.
REQ-020 SHALL implement states IDLE, ST_REQ, ST_WAIT, LD_REQ, LD_WAIT.
REQ-021 IDLE: count>0 -> ST_REQ (takes priority over load acceptance); load accepted -> LD_REQ; else stay.
REQ-022 ST_REQ: mem_req=1, mem_wr=1, mem_* from head entry; mem_addr_ok -> ST_WAIT.
REQ-023 ST_WAIT: mem_req=0; on mem_data_ok pop head; -> ST_REQ if count after pop >0, else IDLE.
REQ-024 LD_REQ: mem_req=1, mem_wr=0, mem_wstrb=0, mem_wdata=0, addr/size from load register; mem_addr_ok -> LD_WAIT.
REQ-025 LD_WAIT: on mem_data_ok, cpu_data_ok=1 and cpu_rdata=mem_rdata same cycle (combinational), -> IDLE.
REQ-026 SHALL keep at most one bridge request outstanding; mem_* stable while mem_req=1 and mem_addr_ok=0.
REQ-027 Simultaneous push (REQ-016) and pop (REQ-023) SHALL leave count unchanged and update both pointers.
REQ-028 Stores accepted while state is ST_REQ/ST_WAIT SHALL drain in acceptance order after earlier entries.
REQ-029 cpu_data_ok responses SHALL be in acceptance order; store-ack pulse and load data_ok never coincide.
REQ-030 cpu_rdata SHALL be 0 when not returning load data; mem_* outputs 0 when mem_req=0.
REQ-031 mem_data_ok received in IDLE/ST_REQ/LD_REQ SHALL be ignored.

Reset
REQ-032 aresetn=0 SHALL immediately force state=IDLE, count=0, pointers=0, pending store-ack=0, all outputs 0.
REQ-033 Reset mid-operation SHALL discard all queued stores and any outstanding load without responding.

Verification
REQ-034 Single store addr 0x1C000100 wdata 0xDEADBEEF wstrb 0xF -> addr_ok same cycle, cpu_data_ok next cycle, mem_req store with same fields, mem_addr_ok then mem_data_ok -> IDLE, count=0.
REQ-035 Back-to-back 5 stores, DEPTH=4, mem_addr_ok held 0 -> first 4 accepted, 5th stalls (addr_ok=0) until first pop, drain order matches acceptance.
REQ-036 Store then load to same addr -> load addr_ok withheld until count=0 and IDLE; load returns mem_rdata 0x12345678 on cpu_rdata with cpu_data_ok in mem_data_ok cycle.
REQ-037 Push and pop same cycle at count=2 -> count stays 2, pointers both advance, wrap from DEPTH-1 to 0 verified.
REQ-038 aresetn low during ST_WAIT with 3 entries -> all outputs 0 immediately, count=0; after release no stale mem_req.
